// File: rtl/upb_axil_pkg.sv
// Shared types and helpers for the AXI4-Lite initiators
// that program the TCAM lookup register space.
package upb_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_XFER,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESPOND
  } axil_master_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  function automatic logic [31:0] word_to_byte_addr(
    input logic [31:0] base,
    input logic [31:0] word
  );
    return base + (word << 2);
  endfunction

endpackage

// File: rtl/upb_axil_timeout.sv
// Per-phase watchdog: counts enabled cycles since the last clear
// and flags the cycle in which the CYCLES-th wait completes.
module upb_axil_timeout #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/upb_tcam_axi_writer.sv
// AXI4-Lite initiator: serialises write commands into single-beat
// writes and read commands into one read, with per-phase timeout.
module upb_tcam_axi_writer
  import upb_axil_pkg::*;
#(
  parameter int unsigned MAX_WORDS       = 8,
  parameter logic [31:0] C_AXI_BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [31:0]                      cmd_addr,
  input  logic [$clog2(MAX_WORDS+1)-1:0]   cmd_len,
  input  logic [32*MAX_WORDS-1:0]          cmd_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_error,
  output logic                             rsp_timeout,
  output logic [$clog2(MAX_WORDS+1)-1:0]   rsp_count,
  output logic [31:0]                      rsp_rdata,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [31:0]                      m_axi_awaddr,
  output logic [2:0]                       m_axi_awprot,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  output logic [31:0]                      m_axi_wdata,
  output logic [3:0]                       m_axi_wstrb,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  input  logic [1:0]                       m_axi_bresp,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  output logic [31:0]                      m_axi_araddr,
  output logic [2:0]                       m_axi_arprot,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready,
  input  logic [31:0]                      m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp
);

  localparam int LW = $clog2(MAX_WORDS + 1);
  localparam int DW = 32 * MAX_WORDS;

  axil_master_state_t state;

  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic [LW-1:0] count;
  logic [DW-1:0] wq;
  logic          aw_done;
  logic          w_done;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic aw_all, w_all, more;
  logic tmo_clear, tmo_en, tmo_hit;

  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid && m_axi_wready;
  assign b_fire  = m_axi_bvalid && m_axi_bready;
  assign ar_fire = m_axi_arvalid && m_axi_arready;
  assign r_fire  = m_axi_rvalid && m_axi_rready;
  assign aw_all  = aw_done || aw_fire;
  assign w_all   = w_done || w_fire;
  assign more    = (idx + LW'(1)) < len_q;

  assign tmo_en = state inside {ST_WR_XFER, ST_WR_RESP,
                                ST_RD_ADDR, ST_RD_DATA};
  assign tmo_clear = aw_fire || w_fire || b_fire
                  || ar_fire || r_fire;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

  upb_axil_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_hit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_count     <= '0;
      rsp_rdata     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
      len_q         <= '0;
      idx           <= '0;
      count         <= '0;
      wq            <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            len_q     <= cmd_len;
            idx       <= '0;
            count     <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (!cmd_write) begin
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= word_to_byte_addr(C_AXI_BASE_ADDR, cmd_addr);
              state         <= ST_RD_ADDR;
            end else if (cmd_len == '0 || cmd_len > LW'(MAX_WORDS)) begin
              rsp_valid   <= 1'b1;
              rsp_error   <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_count   <= '0;
              rsp_rdata   <= '0;
              state       <= ST_RESPOND;
            end else begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_awaddr  <= word_to_byte_addr(C_AXI_BASE_ADDR, cmd_addr);
              m_axi_wdata   <= cmd_wdata[31:0];
              wq            <= cmd_wdata >> 32;
              state         <= ST_WR_XFER;
            end
          end
        end
        ST_WR_XFER: begin
          if (aw_fire) m_axi_awvalid <= 1'b0;
          if (w_fire)  m_axi_wvalid  <= 1'b0;
          aw_done <= aw_all;
          w_done  <= w_all;
          if (aw_all && w_all) begin
            m_axi_bready <= 1'b1;
            state        <= ST_WR_RESP;
          end else if (tmo_hit) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_error     <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_count     <= count;
            rsp_rdata     <= '0;
            state         <= ST_RESPOND;
          end
        end
        ST_WR_RESP: begin
          if (b_fire) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != AXI_RESP_OKAY) begin
              rsp_valid   <= 1'b1;
              rsp_error   <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_count   <= count;
              rsp_rdata   <= '0;
              state       <= ST_RESPOND;
            end else if (more) begin
              count         <= count + LW'(1);
              idx           <= idx + LW'(1);
              m_axi_awaddr  <= m_axi_awaddr + 32'd4;
              m_axi_wdata   <= wq[31:0];
              wq            <= wq >> 32;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= ST_WR_XFER;
            end else begin
              rsp_valid   <= 1'b1;
              rsp_error   <= 1'b0;
              rsp_timeout <= 1'b0;
              rsp_count   <= count + LW'(1);
              rsp_rdata   <= '0;
              state       <= ST_RESPOND;
            end
          end else if (tmo_hit) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b1;
            rsp_timeout  <= 1'b1;
            rsp_count    <= count;
            rsp_rdata    <= '0;
            state        <= ST_RESPOND;
          end
        end
        ST_RD_ADDR: begin
          if (ar_fire) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_DATA;
          end else if (tmo_hit) begin
            m_axi_arvalid <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_error     <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_count     <= '0;
            rsp_rdata     <= '0;
            state         <= ST_RESPOND;
          end
        end
        ST_RD_DATA: begin
          if (r_fire) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_error    <= (m_axi_rresp != AXI_RESP_OKAY);
            rsp_timeout  <= 1'b0;
            rsp_count    <= '0;
            rsp_rdata    <= m_axi_rdata;
            state        <= ST_RESPOND;
          end else if (tmo_hit) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b1;
            rsp_timeout  <= 1'b1;
            rsp_count    <= '0;
            rsp_rdata    <= '0;
            state        <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          // ready is raised on exit so IDLE can accept immediately
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upb_tcam_axi_writer.sv
// Directed bench for upb_tcam_axi_writer with a small
// configurable AXI4-Lite slave model.
module tb_upb_tcam_axi_writer;
  import upb_axil_pkg::*;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_write = 1'b0;
  logic [31:0]  cmd_addr = '0;
  logic [3:0]   cmd_len = '0;
  logic [255:0] cmd_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_error;
  logic         rsp_timeout;
  logic [3:0]   rsp_count;
  logic [31:0]  rsp_rdata;
  logic         m_axi_awvalid;
  logic         m_axi_awready = 1'b0;
  logic [31:0]  m_axi_awaddr;
  logic [2:0]   m_axi_awprot;
  logic         m_axi_wvalid;
  logic         m_axi_wready = 1'b0;
  logic [31:0]  m_axi_wdata;
  logic [3:0]   m_axi_wstrb;
  logic         m_axi_bvalid = 1'b0;
  logic         m_axi_bready;
  logic [1:0]   m_axi_bresp = 2'b00;
  logic         m_axi_arvalid;
  logic         m_axi_arready = 1'b0;
  logic [31:0]  m_axi_araddr;
  logic [2:0]   m_axi_arprot;
  logic         m_axi_rvalid = 1'b0;
  logic         m_axi_rready;
  logic [31:0]  m_axi_rdata = '0;
  logic [1:0]   m_axi_rresp = 2'b00;

  always #5 CLK = ~CLK;

  upb_tcam_axi_writer #(
    .MAX_WORDS       (8),
    .C_AXI_BASE_ADDR (32'h0000_0000),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_error     (rsp_error),
    .rsp_timeout   (rsp_timeout),
    .rsp_count     (rsp_count),
    .rsp_rdata     (rsp_rdata),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp)
  );

  // slave configuration
  int          s_aw_dly, s_w_dly, s_err_word, s_r_dly;
  bit          s_blk, s_b_en;
  logic [31:0] s_rd;
  logic [1:0]  s_rresp;

  // slave bookkeeping and logs
  int          aw_age, w_age, ar_age, r_age;
  int          aw_n, w_n, ar_n, b_n, r_n, aw_hi;
  bit          b_hs, r_hs;
  logic [31:0] aw_log [16];
  logic [31:0] w_log  [16];
  logic [31:0] ar_log [16];

  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge CLK) begin
    if (m_axi_awvalid) aw_hi++;
    if (m_axi_awvalid && m_axi_awready) begin
      if (aw_n < 16) aw_log[aw_n] = m_axi_awaddr;
      aw_n++;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      if (w_n < 16) w_log[w_n] = m_axi_wdata;
      w_n++;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      if (ar_n < 16) ar_log[ar_n] = m_axi_araddr;
      ar_n++;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      b_n++;
      b_hs = 1'b1;
    end
    if (m_axi_rvalid && m_axi_rready) begin
      r_n++;
      r_hs = 1'b1;
    end
  end

  always @(negedge CLK) begin
    aw_age = m_axi_awvalid ? aw_age + 1 : 0;
    w_age  = m_axi_wvalid  ? w_age + 1  : 0;
    ar_age = m_axi_arvalid ? ar_age + 1 : 0;
    m_axi_awready = m_axi_awvalid && !s_blk && (aw_age > s_aw_dly);
    m_axi_wready  = m_axi_wvalid && !s_blk && (w_age > s_w_dly);
    m_axi_arready = m_axi_arvalid && !s_blk && (ar_age > 0);
    if (b_hs) begin
      m_axi_bvalid = 1'b0;
      b_hs = 1'b0;
    end
    if (!m_axi_bvalid && s_b_en && aw_n > b_n && w_n > b_n) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = (b_n + 1 == s_err_word) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    end
    if (r_hs) begin
      m_axi_rvalid = 1'b0;
      r_hs = 1'b0;
      r_age = 0;
    end
    if (!m_axi_rvalid && ar_n > r_n) begin
      r_age++;
      if (r_age > s_r_dly) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = s_rd;
        m_axi_rresp  = s_rresp;
      end
    end
  end

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    int           len;
    logic [255:0] wd;
    int           aw_dly;
    int           w_dly;
    int           err_word;
    bit           blk;
    int           r_dly;
    logic [31:0]  rd;
    logic [1:0]   rresp;
    bit           e_err;
    bit           e_to;
    int           e_cnt;
    logic [31:0]  e_rdata;
    int           e_aw;
    int           e_w;
    int           e_ar;
    logic [31:0]  e_addr0;
    int           e_awhi;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mkw(
    input logic [31:0] addr, input int len, input logic [255:0] wd,
    input int aw_dly, input int w_dly, input int err_word, input bit blk,
    input bit e_err, input bit e_to, input int e_cnt,
    input int e_aw, input int e_w, input logic [31:0] e_addr0,
    input int e_awhi);
    vec_t v;
    v.wr = 1'b1; v.addr = addr; v.len = len; v.wd = wd;
    v.aw_dly = aw_dly; v.w_dly = w_dly; v.err_word = err_word;
    v.blk = blk; v.r_dly = 0; v.rd = '0; v.rresp = AXI_RESP_OKAY;
    v.e_err = e_err; v.e_to = e_to; v.e_cnt = e_cnt; v.e_rdata = '0;
    v.e_aw = e_aw; v.e_w = e_w; v.e_ar = 0; v.e_addr0 = e_addr0;
    v.e_awhi = e_awhi;
    return v;
  endfunction

  function automatic vec_t mkr(
    input logic [31:0] addr, input int r_dly, input logic [31:0] rd,
    input logic [1:0] rresp, input bit blk,
    input bit e_err, input bit e_to, input logic [31:0] e_rdata,
    input int e_ar, input logic [31:0] e_addr0);
    vec_t v;
    v.wr = 1'b0; v.addr = addr; v.len = 0; v.wd = '0;
    v.aw_dly = 0; v.w_dly = 0; v.err_word = 0; v.blk = blk;
    v.r_dly = r_dly; v.rd = rd; v.rresp = rresp;
    v.e_err = e_err; v.e_to = e_to; v.e_cnt = 0; v.e_rdata = e_rdata;
    v.e_aw = 0; v.e_w = 0; v.e_ar = e_ar; v.e_addr0 = e_addr0;
    v.e_awhi = 0;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic slave_clear();
    aw_age = 0; w_age = 0; ar_age = 0; r_age = 0;
    aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0; aw_hi = 0;
    b_hs = 1'b0; r_hs = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  task automatic wait_ready(input string p);
    for (int i = 0; i < 50 && !cmd_ready; i++) begin
      @(posedge CLK); #1;
    end
    check({p, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    string p;
    p = $sformatf("v%0d", id);
    wait_ready(p);
    slave_clear();
    s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_err_word = v.err_word;
    s_blk = v.blk; s_r_dly = v.r_dly; s_rd = v.rd; s_rresp = v.rresp;
    s_b_en = 1'b1;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_len = v.len[3:0]; cmd_wdata = v.wd;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    check({p, ".ready_drop"}, 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      @(posedge CLK); #1;
    end
    check({p, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({p, ".err"}, 32'(rsp_error), 32'(v.e_err));
    check({p, ".timeout"}, 32'(rsp_timeout), 32'(v.e_to));
    check({p, ".count"}, 32'(rsp_count), 32'(v.e_cnt));
    check({p, ".rdata"}, rsp_rdata, v.e_rdata);
    check({p, ".aw_beats"}, 32'(aw_n), 32'(v.e_aw));
    check({p, ".w_beats"}, 32'(w_n), 32'(v.e_w));
    check({p, ".ar_beats"}, 32'(ar_n), 32'(v.e_ar));
    for (int i = 0; i < v.e_aw && i < aw_n && i < 16; i++) begin
      check($sformatf("%s.awaddr%0d", p, i), aw_log[i],
            v.e_addr0 + 32'(4 * i));
    end
    for (int i = 0; i < v.e_w && i < w_n && i < 16; i++) begin
      check($sformatf("%s.wdata%0d", p, i), w_log[i], v.wd[32*i +: 32]);
    end
    if (v.e_ar > 0 && ar_n > 0) begin
      check({p, ".araddr"}, ar_log[0], v.e_addr0);
    end
    if (v.e_awhi >= 0) begin
      check({p, ".aw_hi_cycles"}, 32'(aw_hi), 32'(v.e_awhi));
    end
    @(posedge CLK); #1;
    check({p, ".hold_valid"}, 32'(rsp_valid), 32'd1);
    check({p, ".hold_count"}, 32'(rsp_count), 32'(v.e_cnt));
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    check({p, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    check({p, ".back_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_quiet(input string p);
    check({p, ".awvalid"}, 32'(m_axi_awvalid), 32'd0);
    check({p, ".wvalid"}, 32'(m_axi_wvalid), 32'd0);
    check({p, ".bready"}, 32'(m_axi_bready), 32'd0);
    check({p, ".arvalid"}, 32'(m_axi_arvalid), 32'd0);
    check({p, ".rready"}, 32'(m_axi_rready), 32'd0);
    check({p, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({p, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({p, ".rsp_error"}, 32'(rsp_error), 32'd0);
    check({p, ".rsp_count"}, 32'(rsp_count), 32'd0);
    check({p, ".wstrb"}, 32'(m_axi_wstrb), 32'hF);
    check({p, ".prot"}, 32'({m_axi_awprot, m_axi_arprot}), 32'd0);
  endtask

  initial begin
    logic [255:0] w3, w4, w8, w1;
    w3 = {160'h0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    w4 = {128'h0, 32'h4444_0004, 32'h3333_0003,
          32'h2222_0002, 32'h1111_0001};
    w8 = {32'h8008_0008, 32'h7007_0007, 32'h6006_0006, 32'h5005_0005,
          32'h4004_0004, 32'h3003_0003, 32'h2002_0002, 32'h1001_0001};
    w1 = {224'h0, 32'h0BAD_F00D};

    tbl[0] = mkw(32'h10, 3, w3, 0, 0, 0, 0, 0, 0, 3, 3, 3, 32'h40, -1);
    tbl[1] = mkw(32'h10, 3, w3, 5, 0, 0, 0, 0, 0, 3, 3, 3, 32'h40, -1);
    tbl[2] = mkr(32'h7, 4, 32'hDEAD_BEEF, AXI_RESP_OKAY, 0,
                 0, 0, 32'hDEAD_BEEF, 1, 32'h1C);
    tbl[3] = mkw(32'h100, 4, w4, 0, 0, 2, 0, 1, 0, 1, 2, 2, 32'h400, -1);
    tbl[4] = mkw(32'h5, 1, w1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h14, 16);
    tbl[5] = mkw(32'h10, 0, w3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h40, 0);
    tbl[6] = mkw(32'h10, 9, w8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h40, 0);
    tbl[7] = mkr(32'h3, 1, 32'h1234_5678, AXI_RESP_SLVERR, 0,
                 1, 0, 32'h1234_5678, 1, 32'hC);
    tbl[8] = mkw(32'hFFFF_FFFE, 8, w8, 1, 2, 0, 0,
                 0, 0, 8, 8, 8, 32'hFFFF_FFF8, -1);
    tbl[9] = mkr(32'h9, 0, 32'h0, AXI_RESP_OKAY, 1,
                 1, 1, 32'h0, 0, 32'h24);

    s_aw_dly = 0; s_w_dly = 0; s_err_word = 0; s_r_dly = 0;
    s_blk = 1'b0; s_b_en = 1'b1; s_rd = '0; s_rresp = AXI_RESP_OKAY;
    slave_clear();

    repeat (3) @(posedge CLK);
    #1;
    check_quiet("reset");
    RST = 1'b0;
    @(posedge CLK); #1;
    check("reset.ready_after", 32'(cmd_ready), 32'd1);

    for (int k = 0; k < 10; k++) begin
      run_vec(k, tbl[k]);
    end

    // reset while waiting on the write response
    wait_ready("rst");
    slave_clear();
    s_aw_dly = 0; s_w_dly = 0; s_err_word = 0;
    s_blk = 1'b0; s_b_en = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20;
    cmd_len = 4'd2; cmd_wdata = w4;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !m_axi_bready; i++) begin
      @(posedge CLK); #1;
    end
    check("rst.in_wr_resp", 32'(m_axi_bready), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_quiet("rst.mid");
    @(posedge CLK); #1;
    RST = 1'b0;
    slave_clear();
    s_b_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst.no_rsp", 32'(rsp_valid), 32'd0);
    check("rst.no_aw", 32'(aw_n + w_n), 32'd0);
    run_vec(10, tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/upb_tcam_axi_writer.md
Name: upb_tcam_axi_writer

Overview:
AXI4-Lite initiator that programs and reads back TCAM entries through upb_tcam_lookup's AXI4-Lite slave port. It accepts one command at a time on a valid/ready interface. A write command is serialized into 1..MAX_WORDS single-beat AXI4-Lite writes to consecutive word addresses. A read command becomes one AXI4-Lite read. Sits between the flow-table management logic and the lookup block's register space.

Parameters:
MAX_WORDS, 8, max 32-bit words per write command (1..16)
C_AXI_BASE_ADDR, 32'h00000000, byte base address of target slave
TIMEOUT_CYCLES, 1024, cycles waiting on any single AXI channel before abort (>=4)

Ports:
CLK  in  1  single clock for command side and AXI side
RST  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=write burst, 0=single read
cmd_addr  in  32  first target word address (word units)
cmd_len  in  $clog2(MAX_WORDS+1)  words to write (ignored for reads)
cmd_wdata  in  32*MAX_WORDS  word i at bits [32*i+31:32*i]
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_error  out  1  SLVERR/DECERR, timeout, or illegal length
rsp_timeout  out  1  error cause was timeout
rsp_count  out  $clog2(MAX_WORDS+1)  words successfully written
rsp_rdata  out  32  read data (0 for writes)
m_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  AXI write address (out/in/out/out)
m_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  AXI write data (out/in/out/out)
m_axi_bvalid/bready/bresp[1:0]  AXI write response (in/out/in)
m_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  AXI read address (out/in/out/out)
m_axi_rvalid/rready/rdata[31:0]/rresp[1:0]  AXI read data (in/out/in/in)

Behaviour:
- All outputs registered. On reset: every valid/ready output 0 (including cmd_ready); rsp_* 0; state IDLE; counters 0. awprot=arprot=0, wstrb=4'hF always.
- Reset mid-transaction drops all AXI valids in the next cycle. No response is produced.
- States: IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- IDLE: cmd_ready=1.
  - On accept, latch the command and clear idx, count and error.
  - write with cmd_len==0 or cmd_len>MAX_WORDS: go to RESPOND with rsp_error=1, count=0, no AXI traffic.
  - Any other write: go to WR_XFER. Read: go to RD_ADDR.
  - cmd_ready drops the cycle after accept.
- Address for word i: C_AXI_BASE_ADDR + ((cmd_addr+i)<<2), 32-bit wrap-around.
- WR_XFER:
  - Assert awvalid and wvalid together. Each drops independently on its own handshake; flags aw_done/w_done.
  - Both done: deassert both, go to WR_RESP. The slave may accept W before AW.
- WR_RESP:
  - bready=1. On bvalid with bresp==0: count++.
  - If idx+1<len: idx++, back to WR_XFER; otherwise go to RESPOND.
  - bresp!=0: set error, go to RESPOND. Remaining words are skipped.
- RD_ADDR: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, latch rdata, error=(rresp!=0), go to RESPOND.
- Timeout:
  - A per-phase counter resets on entry to WR_XFER/WR_RESP/RD_ADDR/RD_DATA and on any handshake.
  - Reaching TIMEOUT_CYCLES: drop all AXI valids and readies, set error=1 and timeout=1, go to RESPOND.
  - This covers the slave never completing a handshake, e.g. on an out-of-range address.
- RESPOND: rsp_valid=1, held with stable data until rsp_ready, then go to IDLE. Back-to-back commands need no idle cycle beyond this.
- Exactly one outstanding AXI transaction. No handshake signal depends combinationally on an AXI input.

Decomposition:
- Shared package upb_axil_pkg: state enum axil_master_state_t, response constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10, and helper function word_to_byte_addr.
- One natural sub-module: upb_axil_timeout (load/clear, enable, expire flag), reusable by other initiators.

Test Plan:
- Write len=3, addr=0x10, words A,B,C; slave always ready, OKAY → writes to 0x40, 0x44, 0x48 in order; rsp_error=0, rsp_count=3.
- Same write with slave asserting wready 5 cycles before awready → each word written once, data/address pairing correct, rsp_count=3.
- Read addr=0x7, slave returns rdata=0xDEADBEEF after 4 cycles → araddr=0x1C; rsp_rdata=0xDEADBEEF, rsp_error=0.
- Write len=4, slave returns SLVERR on word 2 → exactly 2 AW beats; rsp_error=1, rsp_count=1.
- Write len=1 to a slave that never asserts awready, TIMEOUT_CYCLES=16 → awvalid drops after 16 cycles; rsp_error=1, rsp_timeout=1, rsp_count=0.
- cmd_len=0, and separately reset asserted during WR_RESP → no AXI traffic and immediate error response for len=0; after reset, all outputs 0 and the next command completes normally.
